d_cell_unit: RTL and testbench
==============================

// Module: d_cell_unit
// PURPOSE
// - Data-side execution unit of the bfcpu core, directly upstream of the data memory.
// - Owns the data pointer and a one-cell write-back cache of the current cell.
// - Executes the data ops issued by the control unit ('>' '<' '+' '-' ',' '.' and flush).
// - Drives the d_req/d_dir/d_addr/d_wdata / d_ack/d_rdata memory handshake.
// PARAMETERS
// - d_addr_width  8'd8    data pointer / memory address width
// - d_mem_length  32'd64  number of cells; the pointer wraps within 0..d_mem_length-1
// PORTS
// - clk        in   1   system clock; all logic on posedge
// - rst_n      in   1   reset, synchronous, active-low
// - op_valid   in   1   control unit presents an op
// - op_code    in   3   NOP, PTR_INC, PTR_DEC, CELL_INC, CELL_DEC, CELL_READ, CELL_WRITE, FLUSH
// - op_wdata   in   8   value for CELL_WRITE (',' input byte)
// - op_ready   out  1   unit idle; op accepted when op_valid && op_ready
// - op_done    out  1   one-cycle pulse when the accepted op has completed
// - cell_value out  8   cached cell value; meaningful only while cell_valid=1
// - cell_zero  out  1   cell_value==0 && cell_valid (for '[' ']' tests)
// - cell_valid out  1   cache holds mem[ptr]
// - d_req      out  1   memory request
// - d_dir      out  1   `DIRECTION_WRITE / `DIRECTION_READ
// - d_addr     out  d_addr_width  equals ptr on every request
// - d_wdata    out  8   write-back data
// - d_ack      in   1   memory acknowledge
// - d_rdata    in   8   memory read data, valid in the cycle d_ack=1
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): ptr=0, cell_valid=0, dirty=0, d_req=0, op_done=0, op_ready=1.
//   Reset aborts any transaction in flight (d_req low next cycle); dirty data is lost.
// - All memory-side outputs are registered and held stable from d_req rise until d_ack.
//   d_req drops the cycle after d_ack and stays low >=1 cycle before the next request.
//   The memory acks continuously while d_req stays high, so this gap is required.
// - FSM states: IDLE -> [WB] -> [GAP] -> [FILL] -> EXEC -> IDLE.
//   - WB: d_req=1, d_dir=WRITE, d_wdata=cell. On ack: dirty=0.
//   - FILL: d_req=1, d_dir=READ. On ack: cell=d_rdata, cell_valid=1.
//   - EXEC: apply the op; op_done=1 for one cycle; op_ready=1 on return to IDLE.
// - Op rules:
//   - PTR_INC/PTR_DEC: WB if dirty. Then ptr +/-1 and cell_valid=0; no fill (lazy).
//     Wrap: d_mem_length-1 -> 0 on INC, 0 -> d_mem_length-1 on DEC.
//   - CELL_INC/CELL_DEC: FILL if !cell_valid. Then cell +/-1 modulo 256 (255+1=0, 0-1=255); dirty=1.
//   - CELL_READ: FILL if !cell_valid; no modification.
//   - CELL_WRITE: no fill; cell=op_wdata, cell_valid=1, dirty=1.
//   - FLUSH: WB if dirty; cache stays valid.
//   - NOP: op_done next cycle.
// - Latency from accept cycle T:
//   - Cache hit, no memory access: op_done at T+1.
//   - Single memory transaction: d_req at T+1, ack at T+2, op_done at T+3.
//   - WB followed by FILL never happens within one op.
// - op_valid while op_ready=0 is ignored (not queued).
// - d_rdata is never used in a write cycle; write-first/read-first BRAM mode is irrelevant.
// STRUCTURE
// - Shared include macros/d_op.vh: op_code encodings, FSM state encodings.
// - Reuses macros/direction.vh for `DIRECTION_READ/`DIRECTION_WRITE.
// - No sub-modules; pointer wrap and cell arithmetic are inline.
// TESTING (bench pairs this unit with d_mem_elf2_v1, preloaded memory)
// - Reset, CELL_READ with mem[0]=8'h05:
//   one read req at addr 0 -> op_done at T+3, cell_value=5, cell_zero=0.
// - CELL_INC x3 on mem[0]=8'hFE:
//   first op fills, later ops complete at T+1 -> cell_value=8'h01, no write yet.
// - Then PTR_INC:
//   write req addr 0 data 8'h01 -> ptr=1, cell_valid=0; mem[0] reads back 1.
// - PTR_DEC from ptr=0 with d_mem_length=64:
//   no write (clean) -> ptr=63; then CELL_WRITE 8'h00 + FLUSH -> mem[63]=0.
// - Back-to-back CELL_READ after PTR_INC:
//   d_req low >=1 cycle between transactions; every d_ack matches exactly one request.
// - rst_n=0 while d_req=1 in WB:
//   d_req=0 next cycle, ptr=0, cell_valid=0, op_ready=1, no op_done pulse.

Source files
------------

// File: rtl/d_cell_unit_pkg.sv
// rtl/d_cell_unit_pkg.sv - op, state and direction encodings for the data cell unit
package d_cell_unit_pkg;

  localparam logic [2:0] op_nop        = 3'd0;
  localparam logic [2:0] op_ptr_inc    = 3'd1;
  localparam logic [2:0] op_ptr_dec    = 3'd2;
  localparam logic [2:0] op_cell_inc   = 3'd3;
  localparam logic [2:0] op_cell_dec   = 3'd4;
  localparam logic [2:0] op_cell_read  = 3'd5;
  localparam logic [2:0] op_cell_write = 3'd6;
  localparam logic [2:0] op_flush      = 3'd7;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_wb   = 2'd1;
  localparam logic [1:0] st_fill = 2'd2;
  localparam logic [1:0] st_exec = 2'd3;

  localparam logic direction_read  = 1'b0;
  localparam logic direction_write = 1'b1;

  // Ops that leave the current cell (or publish it) must write back a dirty cache first.
  function automatic logic op_needs_wb(input logic [2:0] op);
    return (op == op_ptr_inc) || (op == op_ptr_dec) || (op == op_flush);
  endfunction

  function automatic logic op_needs_fill(input logic [2:0] op);
    return (op == op_cell_inc) || (op == op_cell_dec) || (op == op_cell_read);
  endfunction

endpackage

// File: rtl/d_cell_unit.sv
// rtl/d_cell_unit.sv - data pointer and one-cell write-back cache in front of data memory
module d_cell_unit
  import d_cell_unit_pkg::*;
#(
  parameter int unsigned d_addr_width = 8,
  parameter int unsigned d_mem_length = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  input  logic [2:0]              op_code,
  input  logic [7:0]              op_wdata,
  output logic                    op_ready,
  output logic                    op_done,
  output logic [7:0]              cell_value,
  output logic                    cell_zero,
  output logic                    cell_valid,
  output logic                    d_req,
  output logic                    d_dir,
  output logic [d_addr_width-1:0] d_addr,
  output logic [7:0]              d_wdata,
  input  logic                    d_ack,
  input  logic [7:0]              d_rdata
);

  localparam logic [d_addr_width-1:0] last_ptr = d_addr_width'(d_mem_length - 1);
  localparam logic [d_addr_width-1:0] ptr_one  = d_addr_width'(1);

  logic [1:0]              state_q, state_d;
  logic [d_addr_width-1:0] ptr_q, ptr_d;
  logic [7:0]              cell_q, cell_d;
  logic                    valid_q, valid_d;
  logic                    dirty_q, dirty_d;
  logic [2:0]              op_q, op_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    d_req_q, d_req_d;
  logic                    d_dir_q, d_dir_d;
  logic [d_addr_width-1:0] d_addr_q, d_addr_d;
  logic [7:0]              d_wdata_q, d_wdata_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cell_d    = cell_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    d_req_d   = d_req_q;
    d_dir_d   = d_dir_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;

    case (state_q)
      st_idle: begin
        if (op_valid) begin
          op_d    = op_code;
          wdata_d = op_wdata;
          if (op_needs_wb(op_code) && dirty_q) begin
            state_d   = st_wb;
            d_req_d   = 1'b1;
            d_dir_d   = direction_write;
            d_addr_d  = ptr_q;
            d_wdata_d = cell_q;
          end else if (op_needs_fill(op_code) && !valid_q) begin
            state_d  = st_fill;
            d_req_d  = 1'b1;
            d_dir_d  = direction_read;
            d_addr_d = ptr_q;
          end else begin
            state_d = st_exec;
          end
        end
      end
      st_wb: begin
        if (d_ack) begin
          d_req_d = 1'b0;
          dirty_d = 1'b0;
          state_d = st_exec;
        end
      end
      st_fill: begin
        if (d_ack) begin
          d_req_d = 1'b0;
          cell_d  = d_rdata;
          valid_d = 1'b1;
          state_d = st_exec;
        end
      end
      default: begin
        // Pointer moves are lazy: the new cell is only fetched by the op that needs it.
        case (op_q)
          op_ptr_inc: begin
            ptr_d   = (ptr_q == last_ptr) ? '0 : ptr_q + ptr_one;
            valid_d = 1'b0;
          end
          op_ptr_dec: begin
            ptr_d   = (ptr_q == '0) ? last_ptr : ptr_q - ptr_one;
            valid_d = 1'b0;
          end
          op_cell_inc: begin
            cell_d  = cell_q + 8'd1;
            dirty_d = 1'b1;
          end
          op_cell_dec: begin
            cell_d  = cell_q - 8'd1;
            dirty_d = 1'b1;
          end
          op_cell_write: begin
            cell_d  = wdata_q;
            valid_d = 1'b1;
            dirty_d = 1'b1;
          end
          default: begin
          end
        endcase
        state_d = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= st_idle;
      ptr_q     <= '0;
      cell_q    <= 8'd0;
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
      op_q      <= op_nop;
      wdata_q   <= 8'd0;
      d_req_q   <= 1'b0;
      d_dir_q   <= direction_read;
      d_addr_q  <= '0;
      d_wdata_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cell_q    <= cell_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      d_req_q   <= d_req_d;
      d_dir_q   <= d_dir_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  assign op_ready   = (state_q == st_idle);
  assign op_done    = (state_q == st_exec);
  assign cell_value = cell_q;
  assign cell_valid = valid_q;
  assign cell_zero  = valid_q && (cell_q == 8'd0);
  assign d_req      = d_req_q;
  assign d_dir      = d_dir_q;
  assign d_addr     = d_addr_q;
  assign d_wdata    = d_wdata_q;

endmodule

// File: tb/tb_d_cell_unit.sv
// tb/tb_d_cell_unit.sv - directed bench for d_cell_unit with a behavioural data memory
module tb_d_cell_unit;

  localparam logic [2:0] NOP = 3'd0, PINC = 3'd1, PDEC = 3'd2, CINC = 3'd3;
  localparam logic [2:0] CDEC = 3'd4, CRD = 3'd5, CWR = 3'd6, FLUSH = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = NOP;
  logic [7:0] op_wdata = 8'd0;
  logic       op_ready, op_done, cell_zero, cell_valid;
  logic [7:0] cell_value;
  logic       d_req, d_dir;
  logic [7:0] d_addr, d_wdata;
  logic       d_ack = 1'b0;
  logic [7:0] d_rdata = 8'd0;

  logic [7:0] mem [0:63];

  int vec_cnt = 0;
  int err_cnt = 0;

  int req_cnt = 0, ack_cnt = 0, write_cnt = 0, viol_cnt = 0;
  logic [7:0] last_addr, last_wdata;
  logic       last_dir;
  logic       req_prev = 1'b0, ack_prev = 1'b0, dir_prev = 1'b0;
  logic [7:0] addr_prev = 8'd0, wdata_prev = 8'd0;

  d_cell_unit #(.d_addr_width(8), .d_mem_length(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_code(op_code), .op_wdata(op_wdata),
    .op_ready(op_ready), .op_done(op_done),
    .cell_value(cell_value), .cell_zero(cell_zero), .cell_valid(cell_valid),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  // Memory acks one cycle after seeing a request and keeps acking every other cycle if held.
  always @(posedge clk) begin
    d_ack <= d_req && !d_ack;
    if (d_req && !d_ack) begin
      if (d_dir) mem[d_addr[5:0]] <= d_wdata;
      else d_rdata <= mem[d_addr[5:0]];
    end
  end

  always @(negedge clk) begin
    if (d_req && !req_prev) begin
      req_cnt++;
      last_addr = d_addr;
      last_dir = d_dir;
      last_wdata = d_wdata;
      if (d_dir) write_cnt++;
    end
    if (d_ack) ack_cnt++;
    if (d_req && ack_prev) viol_cnt++;
    if (d_req && req_prev && !ack_prev &&
        (d_addr !== addr_prev || d_dir !== dir_prev || d_wdata !== wdata_prev)) viol_cnt++;
    req_prev = d_req;
    ack_prev = d_ack;
    addr_prev = d_addr;
    dir_prev = d_dir;
    wdata_prev = d_wdata;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [7:0] wd, output int lat);
    op_valid = 1'b1;
    op_code = code;
    op_wdata = wd;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    lat = 1;
    while (!op_done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!op_done) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (op_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    vec_cnt++; if (op_done !== 1'b0) begin err_cnt++; $display("FAIL reset_op_done: got %b want 0", op_done); end
    vec_cnt++; if (d_req !== 1'b0) begin err_cnt++; $display("FAIL reset_d_req: got %b want 0", d_req); end
    vec_cnt++; if (cell_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_cell_valid: got %b want 0", cell_valid); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    int lat;
    int r0;
    r0 = req_cnt;
    issue(CRD, 8'd0, lat);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL read_latency: got %0d want 3", lat); end
    vec_cnt++; if (req_cnt - r0 !== 1) begin err_cnt++; $display("FAIL read_req_count: got %0d want 1", req_cnt - r0); end
    vec_cnt++; if (last_addr !== 8'd0 || last_dir !== 1'b0) begin err_cnt++; $display("FAIL read_req: got addr %h dir %b want 00 0", last_addr, last_dir); end
    vec_cnt++; if (cell_value !== 8'h05) begin err_cnt++; $display("FAIL read_value: got %h want 05", cell_value); end
    vec_cnt++; if (cell_zero !== 1'b0 || cell_valid !== 1'b1) begin err_cnt++; $display("FAIL read_flags: got zero %b valid %b want 0 1", cell_zero, cell_valid); end
  endtask

  task automatic test_cell_inc();
    int lat;
    int w0;
    do_reset();
    rst_n = 1'b1;
    mem[0] = 8'hFE;
    @(posedge clk);
    #1;
    w0 = write_cnt;
    issue(CINC, 8'd0, lat);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL inc1_latency: got %0d want 3", lat); end
    issue(CINC, 8'd0, lat);
    vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL inc2_latency: got %0d want 1", lat); end
    vec_cnt++; if (cell_value !== 8'h00 || cell_zero !== 1'b1) begin err_cnt++; $display("FAIL inc_wrap: got %h zero %b want 00 1", cell_value, cell_zero); end
    issue(CINC, 8'd0, lat);
    vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL inc3_latency: got %0d want 1", lat); end
    vec_cnt++; if (cell_value !== 8'h01) begin err_cnt++; $display("FAIL inc_value: got %h want 01", cell_value); end
    vec_cnt++; if (write_cnt - w0 !== 0) begin err_cnt++; $display("FAIL inc_no_write: got %0d want 0", write_cnt - w0); end
  endtask

  task automatic test_ptr_inc();
    int lat;
    int w0;
    w0 = write_cnt;
    issue(PINC, 8'd0, lat);
    vec_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL pinc_latency: got %0d want 3", lat); end
    vec_cnt++; if (write_cnt - w0 !== 1) begin err_cnt++; $display("FAIL pinc_write_count: got %0d want 1", write_cnt - w0); end
    vec_cnt++; if (last_addr !== 8'd0 || last_wdata !== 8'h01 || last_dir !== 1'b1) begin err_cnt++; $display("FAIL pinc_wb: got addr %h data %h dir %b want 00 01 1", last_addr, last_wdata, last_dir); end
    vec_cnt++; if (mem[0] !== 8'h01) begin err_cnt++; $display("FAIL pinc_mem0: got %h want 01", mem[0]); end
    vec_cnt++; if (cell_valid !== 1'b0) begin err_cnt++; $display("FAIL pinc_valid: got %b want 0", cell_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(CRD, 8'd0, lat);
    vec_cnt++; if (lat !== 3 || last_addr !== 8'd1) begin err_cnt++; $display("FAIL b2b_read1: got lat %0d addr %h want 3 01", lat, last_addr); end
    vec_cnt++; if (cell_value !== 8'h11) begin err_cnt++; $display("FAIL b2b_value1: got %h want 11", cell_value); end
    issue(PINC, 8'd0, lat);
    vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL b2b_pinc_clean: got %0d want 1", lat); end
    issue(CRD, 8'd0, lat);
    issue(CRD, 8'd0, lat);
    vec_cnt++; if (lat !== 1 || last_addr !== 8'd2 || cell_value !== 8'h22) begin err_cnt++; $display("FAIL b2b_read2: got lat %0d addr %h val %h want 1 02 22", lat, last_addr, cell_value); end
    vec_cnt++; if (viol_cnt !== 0) begin err_cnt++; $display("FAIL b2b_protocol: got %0d violations want 0", viol_cnt); end
    vec_cnt++; if (ack_cnt !== req_cnt) begin err_cnt++; $display("FAIL b2b_ack_match: got %0d acks want %0d", ack_cnt, req_cnt); end
  endtask

  task automatic test_ptr_dec_wrap();
    int lat;
    int w0;
    do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = write_cnt;
    issue(PDEC, 8'd0, lat);
    vec_cnt++; if (lat !== 1 || write_cnt - w0 !== 0) begin err_cnt++; $display("FAIL pdec_clean: got lat %0d writes %0d want 1 0", lat, write_cnt - w0); end
    issue(CWR, 8'h00, lat);
    vec_cnt++; if (lat !== 1 || cell_value !== 8'h00 || cell_zero !== 1'b1) begin err_cnt++; $display("FAIL cwr: got lat %0d val %h zero %b want 1 00 1", lat, cell_value, cell_zero); end
    issue(CDEC, 8'd0, lat);
    vec_cnt++; if (cell_value !== 8'hFF || cell_zero !== 1'b0) begin err_cnt++; $display("FAIL dec_wrap: got %h zero %b want ff 0", cell_value, cell_zero); end
    issue(CINC, 8'd0, lat);
    vec_cnt++; if (cell_value !== 8'h00) begin err_cnt++; $display("FAIL inc_back: got %h want 00", cell_value); end
    issue(FLUSH, 8'd0, lat);
    vec_cnt++; if (lat !== 3 || last_addr !== 8'd63 || last_wdata !== 8'h00) begin err_cnt++; $display("FAIL flush: got lat %0d addr %h data %h want 3 3f 00", lat, last_addr, last_wdata); end
    vec_cnt++; if (mem[63] !== 8'h00 || cell_valid !== 1'b1) begin err_cnt++; $display("FAIL flush_mem: got mem %h valid %b want 00 1", mem[63], cell_valid); end
    issue(PINC, 8'd0, lat);
    vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL pinc_wrap_clean: got %0d want 1", lat); end
    issue(CRD, 8'd0, lat);
    vec_cnt++; if (last_addr !== 8'd0 || cell_value !== 8'h01) begin err_cnt++; $display("FAIL pinc_wrap: got addr %h val %h want 00 01", last_addr, cell_value); end
  endtask

  task automatic test_reset_in_wb();
    int lat;
    int seen_done;
    issue(PINC, 8'd0, lat);
    issue(CWR, 8'h77, lat);
    op_valid = 1'b1;
    op_code = FLUSH;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    vec_cnt++; if (d_req !== 1'b1 || d_dir !== 1'b1) begin err_cnt++; $display("FAIL wb_started: got req %b dir %b want 1 1", d_req, d_dir); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vec_cnt++; if (d_req !== 1'b0 || op_ready !== 1'b1) begin err_cnt++; $display("FAIL wb_abort: got req %b ready %b want 0 1", d_req, op_ready); end
    vec_cnt++; if (cell_valid !== 1'b0 || op_done !== 1'b0) begin err_cnt++; $display("FAIL wb_abort_state: got valid %b done %b want 0 0", cell_valid, op_done); end
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (op_done) seen_done++;
    end
    vec_cnt++; if (seen_done !== 0) begin err_cnt++; $display("FAIL wb_abort_no_done: got %0d pulses want 0", seen_done); end
    issue(CRD, 8'd0, lat);
    vec_cnt++; if (lat !== 3 || last_addr !== 8'd0) begin err_cnt++; $display("FAIL wb_abort_ptr: got lat %0d addr %h want 3 00", lat, last_addr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h05;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    mem[63] = 8'hAA;
    test_reset();
    test_read();
    test_cell_inc();
    test_ptr_inc();
    test_back_to_back();
    test_ptr_dec_wrap();
    test_reset_in_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
